// File: rtl/control_sequencer_pkg.sv
// Shared opcode map, FSM state encoding, instruction classes and strobe bundle for control_sequencer.
// Pure declarations; no timing or flow control of its own.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_UNARY, CL_MULDIV, CL_LD, CL_ST,
        CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
    } iclass_t;

    typedef struct packed {
        logic pc_out;  logic pc_in;   logic inc_pc;  logic ir_in;
        logic mar_in;  logic mdr_in;  logic mdr_out; logic rd;     logic wr;
        logic y_in;    logic zlo_in;  logic zhi_in;  logic zlo_out; logic zhi_out;
        logic hi_in;   logic lo_in;   logic hi_out;  logic lo_out;
        logic gra;     logic grb;     logic grc;     logic r_in;   logic r_out;
        logic ba_out;  logic c_out;
    } strobe_t;

    function automatic iclass_t decode_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       return CL_IMM;
            OP_NEG, OP_NOT:                 return CL_UNARY;
            OP_MUL, OP_DIV:                 return CL_MULDIV;
            OP_LD:                          return CL_LD;
            OP_ST:                          return CL_ST;
            OP_MFHI:                        return CL_MFHI;
            OP_MFLO:                        return CL_MFLO;
            OP_NOP:                         return CL_NOP;
            OP_HALT:                        return CL_HALT;
            default:                        return CL_ILLEGAL;
        endcase
    endfunction

    // States in which the sequencer holds for mem_ready.
    function automatic logic is_wait(input state_t s, input iclass_t k);
        return (s == S_T1) || (s == S_T6 && k == CL_LD) || (s == S_T7 && k == CL_ST);
    endfunction

endpackage

// File: rtl/control_sequencer_wait_timer.sv
// Per-access memory wait timer: expired flags the MAX_WAIT-th consecutive not-ready cycle (MAX_WAIT=0 never expires).
// Latency: expired is combinational from the count and busy; start clears the count for the next cycle.
// Backpressure: none; purely observes the wait.
module ctrl_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic clr,
    input  logic start,
    input  logic busy,
    output logic expired
);
    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (busy && cnt_q != '1) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (MAX_WAIT != 0) && busy && (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer for the single-bus datapath; CTRL_SINGLE_STEP_EN adds step_mode/step.
// Latency: strobes decode combinationally from the current state; fetch 3 cycles, execute 1-5 cycles.
// Backpressure: holds in T1 / LD-T6 / ST-T7 until mem_ready, faulting after MAX_WAIT not-ready cycles.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPW      = 5,
    parameter int MAX_WAIT = 255
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic           step_mode,
    input  logic           step,
`endif
    output logic           PCout,
    output logic           PCin,
    output logic           IncPC,
    output logic           IRin,
    output logic           MARin,
    output logic           MDRin,
    output logic           MDRout,
    output logic           Read,
    output logic           Write,
    output logic           Yin,
    output logic           Zlowin,
    output logic           Zhighin,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           HIin,
    output logic           LOin,
    output logic           HIout,
    output logic           LOout,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           Cout,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           fault
);
    state_t         state_q, state_d;
    iclass_t        cls;
    strobe_t        c;
    logic [OPW-1:0] opcode, aop;
    logic           step_go, mem_busy, wait_start, timeout;
    logic           unused_ir;

    assign opcode    = ir[31 -: OPW];
    assign cls       = decode_class(ir[31:27]);
    assign unused_ir = ^ir[31-OPW:0];

`ifdef CTRL_SINGLE_STEP_EN
    assign step_go = ~step_mode | step;
`else
    assign step_go = 1'b1;
`endif

    assign mem_busy   = is_wait(state_q, cls) & ~mem_ready;
    assign wait_start = is_wait(state_d, cls) && (state_d != state_q);

    ctrl_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .clr     (clr),
        .start   (wait_start),
        .busy    (mem_busy),
        .expired (timeout)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  if (step_go) state_d = S_T1;
            S_T1:  if (mem_ready) state_d = S_T2; else if (timeout) state_d = S_FAULT;
            S_T2:  state_d = S_T3;
            S_T3: begin
                case (cls)
                    CL_MFHI, CL_MFLO, CL_NOP: state_d = S_T0;
                    CL_HALT:                  state_d = S_HALT;
                    CL_ILLEGAL:               state_d = S_FAULT;
                    default:                  state_d = S_T4;
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_UNARY:                                state_d = S_T0;
                    CL_ALU, CL_IMM, CL_MULDIV, CL_LD, CL_ST: state_d = S_T5;
                    default:                                 state_d = S_FAULT;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_ALU, CL_IMM:             state_d = S_T0;
                    CL_MULDIV, CL_LD, CL_ST:    state_d = S_T6;
                    default:                    state_d = S_FAULT;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_MULDIV: state_d = S_T0;
                    CL_ST:     state_d = S_T7;
                    CL_LD:     if (mem_ready) state_d = S_T7; else if (timeout) state_d = S_FAULT;
                    default:   state_d = S_FAULT;
                endcase
            end
            S_T7: begin
                case (cls)
                    CL_LD:   state_d = S_T0;
                    CL_ST:   if (mem_ready) state_d = S_T0; else if (timeout) state_d = S_FAULT;
                    default: state_d = S_FAULT;
                endcase
            end
            default: state_d = state_q;
        endcase
    end

    // Strobe decode; LD/ST address generation forces ADD regardless of opcode.
    always_comb begin
        c   = '0;
        aop = '0;
        case (state_q)
            S_T0: if (step_go) begin
                c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlo_in = 1'b1;
            end
            S_T1: begin c.zlo_out = 1'b1; c.pc_in = 1'b1; c.rd = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_T3: begin
                case (cls)
                    CL_ALU, CL_IMM: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                    CL_UNARY:  begin c.grb = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; aop = opcode; end
                    CL_MULDIV: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                    CL_LD, CL_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
                    CL_MFHI:   begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    CL_MFLO:   begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_ALU:    begin c.grc = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; aop = opcode; end
                    CL_IMM:    begin c.c_out = 1'b1; c.zlo_in = 1'b1; aop = opcode; end
                    CL_UNARY:  begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    CL_MULDIV: begin
                        c.grb = 1'b1; c.r_out = 1'b1; c.zlo_in = 1'b1; c.zhi_in = 1'b1; aop = opcode;
                    end
                    CL_LD, CL_ST: begin c.c_out = 1'b1; c.zlo_in = 1'b1; aop = OPW'(OP_ADD); end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_ALU, CL_IMM: begin c.zlo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    CL_MULDIV:      begin c.zlo_out = 1'b1; c.lo_in = 1'b1; end
                    CL_LD, CL_ST:   begin c.zlo_out = 1'b1; c.mar_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_MULDIV: begin c.zhi_out = 1'b1; c.hi_in = 1'b1; end
                    CL_LD:     begin c.rd = 1'b1; c.mdr_in = 1'b1; end
                    CL_ST:     begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CL_LD:   begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                    CL_ST:   c.wr = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign run    = !(state_q inside {S_RST, S_HALT, S_FAULT});
    assign fault  = (state_q == S_FAULT);
    assign alu_op = aop;

    assign PCout    = c.pc_out;
    assign PCin     = c.pc_in;
    assign IncPC    = c.inc_pc;
    assign IRin     = c.ir_in;
    assign MARin    = c.mar_in;
    assign MDRin    = c.mdr_in;
    assign MDRout   = c.mdr_out;
    assign Read     = c.rd;
    assign Write    = c.wr;
    assign Yin      = c.y_in;
    assign Zlowin   = c.zlo_in;
    assign Zhighin  = c.zhi_in;
    assign Zlowout  = c.zlo_out;
    assign Zhighout = c.zhi_out;
    assign HIin     = c.hi_in;
    assign LOin     = c.lo_in;
    assign HIout    = c.hi_out;
    assign LOout    = c.lo_out;
    assign Gra      = c.gra;
    assign Grb      = c.grb;
    assign Grc      = c.grc;
    assign Rin      = c.r_in;
    assign Rout     = c.r_out;
    assign BAout    = c.ba_out;
    assign Cout     = c.c_out;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe sequences with random waits and operands.
module tb_control_sequencer;
    localparam int MW = 4;

    typedef logic [24:0] sv_t;
    localparam sv_t NONE = '0;
    localparam sv_t PCOUT = sv_t'(1) << 24, PCIN = sv_t'(1) << 23, INCPC = sv_t'(1) << 22,
                    IRIN = sv_t'(1) << 21, MARIN = sv_t'(1) << 20, MDRIN = sv_t'(1) << 19,
                    MDROUT = sv_t'(1) << 18, READ = sv_t'(1) << 17, WRITE = sv_t'(1) << 16,
                    YIN = sv_t'(1) << 15, ZLOWIN = sv_t'(1) << 14, ZHIGHIN = sv_t'(1) << 13,
                    ZLOWOUT = sv_t'(1) << 12, ZHIGHOUT = sv_t'(1) << 11, HIIN = sv_t'(1) << 10,
                    LOIN = sv_t'(1) << 9, HIOUT = sv_t'(1) << 8, LOOUT = sv_t'(1) << 7,
                    GRA = sv_t'(1) << 6, GRB = sv_t'(1) << 5, GRC = sv_t'(1) << 4,
                    RIN = sv_t'(1) << 3, ROUT = sv_t'(1) << 2, BAOUT = sv_t'(1) << 1,
                    COUT = sv_t'(1);

    typedef struct {
        sv_t         s;
        logic [4:0]  op;
        logic        run;
        logic        flt;
        logic        mr;
        logic        st;
        logic [31:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr, mem_ready;
    logic [31:0] ir;
    logic        PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
    logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, run, fault;
    logic [4:0]  alu_op;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step_mode, step;
`endif

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [31:0] cur_ir;
    sv_t         obs;
    logic [4:0]  legal   [20] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                  5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd23, 5'd24, 5'd25};
    logic [4:0]  illegal [11] = '{5'd1, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};

    control_sequencer #(.OPW(5), .MAX_WAIT(MW)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
`ifdef CTRL_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .alu_op(alu_op), .run(run), .fault(fault)
    );

    assign obs = {PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write, Yin, Zlowin, Zhighin,
                  Zlowout, Zhighout, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout, BAout, Cout};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s at %0t observed %h expected %h", tag, $time, got, want);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic push(input sv_t s, input logic [4:0] op, input logic mr);
        exp_t e;
        e.s = s; e.op = op; e.run = 1'b1; e.flt = 1'b0; e.mr = mr; e.st = 1'b0; e.ir = cur_ir;
        q.push_back(e);
    endtask

    task automatic push_term(input logic flt, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.s = NONE; e.op = 5'd0; e.run = 1'b0; e.flt = flt; e.mr = rnd(); e.st = 1'b0; e.ir = cur_ir;
            q.push_back(e);
        end
    endtask

    // w not-ready cycles then a ready one; w >= MW ends in FAULT after MW cycles.
    task automatic push_wait(input sv_t s, input int w, output bit to);
        to = (w >= MW);
        for (int i = 0; i < (to ? MW : w); i++) push(s, 5'd0, 1'b0);
        if (to) push_term(1'b1, 6);
        else    push(s, 5'd0, 1'b1);
    endtask

    task automatic build(input logic [31:0] iv, input int w1, input int w2);
        logic [4:0] opc;
        bit         to;
        opc    = iv[31:27];
        cur_ir = iv;
        push(PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, rnd());
        push_wait(ZLOWOUT | PCIN | READ | MDRIN, w1, to);
        if (to) return;
        push(MDROUT | IRIN, 5'd0, rnd());
        if (opc inside {[5'd3:5'd10]}) begin
            push(GRB | ROUT | YIN, 5'd0, rnd());
            push(GRC | ROUT | ZLOWIN, opc, rnd());
            push(ZLOWOUT | GRA | RIN, 5'd0, rnd());
        end else if (opc inside {[5'd11:5'd13]}) begin
            push(GRB | ROUT | YIN, 5'd0, rnd());
            push(COUT | ZLOWIN, opc, rnd());
            push(ZLOWOUT | GRA | RIN, 5'd0, rnd());
        end else if (opc inside {5'd16, 5'd17}) begin
            push(GRB | ROUT | ZLOWIN, opc, rnd());
            push(ZLOWOUT | GRA | RIN, 5'd0, rnd());
        end else if (opc inside {5'd14, 5'd15}) begin
            push(GRA | ROUT | YIN, 5'd0, rnd());
            push(GRB | ROUT | ZLOWIN | ZHIGHIN, opc, rnd());
            push(ZLOWOUT | LOIN, 5'd0, rnd());
            push(ZHIGHOUT | HIIN, 5'd0, rnd());
        end else if (opc inside {5'd0, 5'd2}) begin
            push(GRB | BAOUT | YIN, 5'd0, rnd());
            push(COUT | ZLOWIN, 5'd3, rnd());
            push(ZLOWOUT | MARIN, 5'd0, rnd());
            if (opc == 5'd0) begin
                push_wait(READ | MDRIN, w2, to);
                if (!to) push(MDROUT | GRA | RIN, 5'd0, rnd());
            end else begin
                push(GRA | ROUT | MDRIN, 5'd0, rnd());
                push_wait(WRITE, w2, to);
            end
        end else if (opc == 5'd23) begin
            push(HIOUT | GRA | RIN, 5'd0, rnd());
        end else if (opc == 5'd24) begin
            push(LOOUT | GRA | RIN, 5'd0, rnd());
        end else if (opc == 5'd25) begin
            push(NONE, 5'd0, rnd());
        end else begin
            push(NONE, 5'd0, rnd());
            push_term(opc != 5'd26, 10);
        end
    endtask

    task automatic run_q(input int n);
        exp_t e;
        int   k;
        k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            e = q.pop_front();
            @(negedge clk);
            mem_ready = e.mr;
            ir        = e.ir;
`ifdef CTRL_SINGLE_STEP_EN
            step      = e.st;
`endif
            #1;
            chk("strobes", 32'(obs), 32'(e.s));
            chk("alu_op", 32'(alu_op), 32'(e.op));
            chk("run", 32'(run), 32'(e.run));
            chk("fault", 32'(fault), 32'(e.flt));
            k++;
        end
    endtask

    task automatic release_clr();
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_cycle_strobes", 32'(obs), 32'(NONE));
        chk("rst_cycle_run", 32'(run), 32'd0);
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("reset_strobes", 32'(obs), 32'(NONE));
        chk("reset_alu_op", 32'(alu_op), 32'd0);
        chk("reset_run", 32'(run), 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        release_clr();
    endtask

    function automatic logic [31:0] rand_ir(input logic [4:0] opc);
        return {opc, 27'($urandom)};
    endfunction

    initial begin
        clr = 1'b0; mem_ready = 1'b0; ir = '0; cur_ir = '0;
`ifdef CTRL_SINGLE_STEP_EN
        step_mode = 1'b0; step = 1'b0;
`endif
        do_reset();

        // Directed: ADD, LD with 3-cycle data wait, MUL followed by MFHI.
        build(32'h18888000, 0, 0);
        build(rand_ir(5'd0), 0, 3);
        build(rand_ir(5'd14), 1, 0);
        build(rand_ir(5'd23), 0, 0);
        run_q(-1);

        // Random legal instruction stream with waits below the timeout.
        repeat (150) begin
            build(rand_ir(legal[$urandom_range(19, 0)]), $urandom_range(3, 0), $urandom_range(3, 0));
            run_q(-1);
        end

        // Directed terminal cases: illegal 11111, HALT, T1 timeout.
        do_reset();
        build(rand_ir(5'd31), 0, 0);
        run_q(-1);
        do_reset();
        build(rand_ir(5'd26), 0, 0);
        run_q(-1);
        do_reset();
        build(rand_ir(5'd3), 100, 0);
        run_q(-1);

        // Random episodes each ending in a terminal condition.
        repeat (12) begin
            do_reset();
            repeat (2) build(rand_ir(legal[$urandom_range(19, 0)]), $urandom_range(3, 0), $urandom_range(3, 0));
            case ($urandom_range(4, 0))
                0: build(rand_ir(illegal[$urandom_range(10, 0)]), 0, 0);
                1: build(rand_ir(5'd26), $urandom_range(3, 0), 0);
                2: build(rand_ir(legal[$urandom_range(19, 0)]), MW + $urandom_range(3, 0), 0);
                3: build(rand_ir(5'd0), 0, MW + $urandom_range(3, 0));
                default: build(rand_ir(5'd2), 0, MW + $urandom_range(3, 0));
            endcase
            run_q(-1);
        end

        // Reset asserted in the middle of an ADD's T5.
        do_reset();
        build(32'h18888000, 0, 0);
        run_q(6);
        clr = 1'b0;
        #1;
        chk("midT5_strobes", 32'(obs), 32'(NONE));
        chk("midT5_run", 32'(run), 32'd0);
        q.delete();
        release_clr();
        build(rand_ir(5'd25), 0, 0);
        run_q(-1);

`ifdef CTRL_SINGLE_STEP_EN
        begin
            int n0;
            step_mode = 1'b1;
            do_reset();
            repeat (5) push(NONE, 5'd0, rnd());
            n0 = q.size();
            build(rand_ir(5'd25), 0, 0);
            q[n0].st = 1'b1;
            repeat (5) push(NONE, 5'd0, rnd());
            run_q(-1);
            step_mode = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
